tx_st_hip_arbiter: RTL and testbench
====================================

# tx_st_hip_arbiter

Arbitrates between the application TX requesters (4KB DMA engines, completion generator) and drives the single Avalon-ST TX interface of the PCIe hard IP. Each requester holds a request for a multi-TLP burst; the arbiter grants one requester at a time, round-robin. It muxes the granted requester's stream through one register stage to the HIP and flags protocol violations. It sits directly downstream of the TX DMA engines in `bali_pcie_app`.

## Interface
- `REQS`, default 2: number of requesters.
- `REQ_WIDTH`, default `$clog2(REQS)`: width of the granted-index output.
- `iCLK` in 1: application clock, shared with the requesters and the HIP TX.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iREQ` in `[REQS-1:0]`: burst request per requester; held high from request through the burst's last EOP.
- `oGNT` in/out: output `[REQS-1:0]`, one-hot grant, registered.
- `iTX_ST` in `[REQS-1:0]` × `pcie_app_pkg::tx_st_avalon_type`: sop, eop, valid, empty, err, parity per requester.
- `iTX_DATA` in `[REQS-1:0][255:0]`: payload per requester.
- `iHIP_TX_READY` in 1: HIP ready for TX.
- `oTX_ST` out `tx_st_avalon_type`: registered, muxed stream to the HIP.
- `oTX_DATA` out 256: registered, muxed data.
- `oGNT_IDX` out `REQ_WIDTH`: index of the current or most recent grant.
- `oERR_STICKY` out 2: bit0 = ready dropped mid-burst; bit1 = valid from a non-granted requester.
- `iCLR_ERR` in 1: synchronous clear of `oERR_STICKY`.
- `oTLP_CNT` out `[REQS-1:0][31:0]`: present only with `TX_ARB_STATS_EN`.

## Operation
- **FSM states:** ARB_ST, GNT_ST, RELEASE_ST.
- **ARB_ST:**
  - If `iHIP_TX_READY` is high and any `iREQ` is set, select the first requester set in round-robin order, starting at `last_idx+1` and wrapping modulo `REQS`.
  - Assert `oGNT[sel]` the next cycle and move to GNT_ST.
- **GNT_ST:**
  - Hold the grant while `iREQ[gnt_idx]` is high.
  - When `iREQ[gnt_idx]` is low, drop `oGNT`, set `last_idx <= gnt_idx`, and move to RELEASE_ST.
- **RELEASE_ST:** one dead cycle, then return to ARB_ST. This guarantees at least one idle cycle between bursts.
- **Mux:**
  - In GNT_ST, register `iTX_ST[gnt_idx]` and `iTX_DATA[gnt_idx]` into the outputs.
  - In every other state, `oTX_ST.valid/sop/eop` = 0, `empty` = `AVALON_255_0_VALID`, and data = 0.
  - `err` and `parity` pass through unchanged.
- **Error bit0:** set when `iHIP_TX_READY` = 0 while `oTX_ST.valid` = 1. The data is still presented; requesters cannot stall, so this is a fatal configuration or credit error.
- **Error bit1:** set when `iTX_ST[i].valid` = 1 with `oGNT[i]` = 0.
- **Sticky bits:** hold until `iCLR_ERR`. If a set event and `iCLR_ERR` occur in the same cycle, set wins.
- **Simultaneous requests:** resolved by round-robin only; no fixed priority.
- **Requester with no grant:** a requester that drops `iREQ` before it is granted is simply skipped.
- **Reset, all outputs:** `oGNT` = 0, `oTX_ST` valid/sop/eop = 0, `empty` = `AVALON_255_0_VALID`, `oTX_DATA` = 0, `oGNT_IDX` = 0, `oERR_STICKY` = 0, counters = 0.
- **Reset internal state:** `last_idx` = `REQS-1`, so requester 0 wins first.
- **Reset mid-burst:** the FSM returns to ARB_ST immediately. Any partial TLP already sent to the HIP is not completed, and the requesters are reset by the same `iRST_N`.

## Timing
- Request to grant: `iREQ` sampled in ARB_ST at edge N → `oGNT` high after edge N+1.
- Grant to data: requester SOP driven in cycle k → `oTX_ST.sop` at HIP in cycle k+1. Fixed latency of 1 for all signals.
- Release: `iREQ` low at edge M → `oGNT` low after M+1. The earliest next grant is after M+3.
- No combinational path from any input to any output.

## Configuration
- `TX_ARB_STATS_EN` defined:
  - `oTLP_CNT[i]` increments on every registered `oTX_ST.eop & valid` sourced from requester i.
  - The counters wrap at 2^32 and are cleared by `iCLR_ERR`.
- `TX_ARB_STATS_EN` undefined: the port and the counters are absent.

## Structure
- `pcie_app_pkg`:
  - `tx_st_avalon_type`, `AVALON_255_0_VALID`, `AVALON_127_0_VALID` (already present).
  - Add `tx_arb_state_e` and `TX_ARB_ERR_READY_BIT` / `TX_ARB_ERR_UNGNT_BIT` constants.
- One sub-module, `rr_arbiter`: a parameterised round-robin selector. It takes the request vector and `last_idx` and returns a one-hot select plus an index; it is purely combinational. The FSM, mux, errors and counters stay in the top level.

## Test plan
- **Single requester:** req0 high, ready=1, two TLPs of 9 beats → `oGNT`=01 after 1 cycle; HIP sees sop/eop identical to the input delayed 1 cycle; `oERR_STICKY`=0.
- **Round-robin:** req0 and req1 asserted together, each releasing after one burst → grant order 0,1,0,1 with ≥1 idle cycle between bursts.
- **Ready low at arbitration:** ready=0 with req0 high → no grant. Raise ready → grant after 1 cycle.
- **Ready drop mid-burst:** ready low for 1 cycle during a burst → `oERR_STICKY`=01 and data unchanged. `iCLR_ERR` → 00.
- **Ungranted valid:** requester 1 asserts valid while requester 0 is granted → `oERR_STICKY[1]`=1; its data never appears on `oTX_DATA`.
- **Reset mid-burst:** `iRST_N` low in the 5th beat → all outputs at reset values immediately. After release, req1 alone is granted first.

Source files
------------

// File: rtl/pcie_app_pkg.sv
// Shared PCIe application types: HIP Avalon-ST TX beat descriptor, empty encodings,
// and the TX arbiter state/error-bit definitions.
package pcie_app_pkg;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        valid;
    logic [1:0]  empty;
    logic        err;
    logic [31:0] parity;
  } tx_st_avalon_type;

  // empty counts unused 64-bit words in the top of the 256-bit beat
  localparam logic [1:0] AVALON_255_0_VALID = 2'b00;
  localparam logic [1:0] AVALON_127_0_VALID = 2'b10;

  typedef enum logic [1:0] {
    ARB_ST     = 2'd0,
    GNT_ST     = 2'd1,
    RELEASE_ST = 2'd2
  } tx_arb_state_e;

  localparam int unsigned TX_ARB_ERR_READY_BIT = 0;
  localparam int unsigned TX_ARB_ERR_UNGNT_BIT = 1;

endpackage

// File: rtl/tx_st_hip_arbiter_rr.sv
// Combinational round-robin selector: first set request after iLAST_IDX, wrapping.
module rr_arbiter #(
  parameter int unsigned REQS      = 2,
  parameter int unsigned REQ_WIDTH = $clog2(REQS)
) (
  input  logic [REQS-1:0]      iREQ,
  input  logic [REQ_WIDTH-1:0] iLAST_IDX,
  output logic [REQS-1:0]      oSEL,
  output logic [REQ_WIDTH-1:0] oSEL_IDX,
  output logic                 oVALID
);

  logic [REQ_WIDTH-1:0] cand;

  always_comb begin
    oSEL     = '0;
    oSEL_IDX = '0;
    oVALID   = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= REQS; k++) begin
      cand = REQ_WIDTH'((32'(iLAST_IDX) + k) % REQS);
      if (!oVALID && iREQ[cand]) begin
        oVALID     = 1'b1;
        oSEL_IDX   = cand;
        oSEL[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_st_hip_arbiter.sv
// Round-robin arbiter muxing requester Avalon-ST TX bursts onto the PCIe HIP TX port.
// Optional per-requester TLP counters are built when TX_ARB_STATS_EN is defined.
module tx_st_hip_arbiter
  import pcie_app_pkg::*;
#(
  parameter int unsigned REQS      = 2,
  parameter int unsigned REQ_WIDTH = $clog2(REQS)
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic [REQS-1:0]              iREQ,
  output logic [REQS-1:0]              oGNT,
  input  tx_st_avalon_type [REQS-1:0]  iTX_ST,
  input  logic [REQS-1:0][255:0]       iTX_DATA,
  input  logic                         iHIP_TX_READY,
  output tx_st_avalon_type             oTX_ST,
  output logic [255:0]                 oTX_DATA,
  output logic [REQ_WIDTH-1:0]         oGNT_IDX,
  output logic [1:0]                   oERR_STICKY,
  input  logic                         iCLR_ERR
`ifdef TX_ARB_STATS_EN
  ,
  output logic [REQS-1:0][31:0]        oTLP_CNT
`endif
);

  tx_arb_state_e        state_q;
  logic [REQS-1:0]      gnt_q;
  logic [REQ_WIDTH-1:0] gnt_idx_q;
  logic [REQ_WIDTH-1:0] last_idx_q;

  logic [REQS-1:0]      rr_sel;
  logic [REQ_WIDTH-1:0] rr_idx;
  logic                 rr_vld;

  tx_st_avalon_type     tx_d, tx_q;
  logic [255:0]         data_d, data_q;
  logic [1:0]           err_set, err_d, err_q;
  logic [REQS-1:0]      valid_vec;

  rr_arbiter #(
    .REQS      (REQS),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_rr (
    .iREQ      (iREQ),
    .iLAST_IDX (last_idx_q),
    .oSEL      (rr_sel),
    .oSEL_IDX  (rr_idx),
    .oVALID    (rr_vld)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ARB_ST;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= REQ_WIDTH'(REQS - 1);
    end else begin
      case (state_q)
        ARB_ST: begin
          if (iHIP_TX_READY && rr_vld) begin
            gnt_q     <= rr_sel;
            gnt_idx_q <= rr_idx;
            state_q   <= GNT_ST;
          end
        end
        GNT_ST: begin
          if (!iREQ[gnt_idx_q]) begin
            gnt_q      <= '0;
            last_idx_q <= gnt_idx_q;
            state_q    <= RELEASE_ST;
          end
        end
        RELEASE_ST: state_q <= ARB_ST;
        default:    state_q <= ARB_ST;
      endcase
    end
  end

  // err/parity keep following the most recent grantee even while idle
  always_comb begin
    tx_d   = iTX_ST[gnt_idx_q];
    data_d = iTX_DATA[gnt_idx_q];
    if (state_q != GNT_ST) begin
      tx_d.sop   = 1'b0;
      tx_d.eop   = 1'b0;
      tx_d.valid = 1'b0;
      tx_d.empty = AVALON_255_0_VALID;
      data_d     = '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < REQS; i++) begin
      valid_vec[i] = iTX_ST[i].valid;
    end
    err_set                       = '0;
    err_set[TX_ARB_ERR_READY_BIT] = !iHIP_TX_READY && tx_q.valid;
    err_set[TX_ARB_ERR_UNGNT_BIT] = |(valid_vec & ~gnt_q);
    err_d = (iCLR_ERR ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tx_q       <= '0;
      tx_q.empty <= AVALON_255_0_VALID;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      tx_q   <= tx_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign oGNT        = gnt_q;
  assign oGNT_IDX    = gnt_idx_q;
  assign oTX_ST      = tx_q;
  assign oTX_DATA    = data_q;
  assign oERR_STICKY = err_q;

`ifdef TX_ARB_STATS_EN
  logic [REQS-1:0][31:0] cnt_d, cnt_q;

  // gnt_idx_q is stable until the next grant, so it still names the source of
  // the beat registered in the cycle after the grant drops
  always_comb begin
    for (int unsigned i = 0; i < REQS; i++) begin
      cnt_d[i] = (iCLR_ERR ? 32'd0 : cnt_q[i]) +
                 ((tx_q.valid && tx_q.eop && gnt_idx_q == REQ_WIDTH'(i)) ? 32'd1 : 32'd0);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oTLP_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_tx_st_hip_arbiter.sv
// Bench for tx_st_hip_arbiter: scripted vector table, directed corner sequences and
// randomized requester traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_tx_st_hip_arbiter;
  import pcie_app_pkg::*;

  localparam int REQS = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [1:0]                  req;
  logic [1:0]                  gnt;
  tx_st_avalon_type [1:0]      in_st;
  logic [1:0][255:0]           in_data;
  logic                        rdy;
  tx_st_avalon_type            out_st;
  logic [255:0]                out_data;
  logic [0:0]                  gnt_idx;
  logic [1:0]                  err;
  logic                        clr;
`ifdef TX_ARB_STATS_EN
  logic [1:0][31:0]            tlp_cnt;
`endif

  always #5 clk = ~clk;

  tx_st_hip_arbiter #(.REQS(2), .REQ_WIDTH(1)) dut (
    .iCLK          (clk),
    .iRST_N        (rst_n),
    .iREQ          (req),
    .oGNT          (gnt),
    .iTX_ST        (in_st),
    .iTX_DATA      (in_data),
    .iHIP_TX_READY (rdy),
    .oTX_ST        (out_st),
    .oTX_DATA      (out_data),
    .oGNT_IDX      (gnt_idx),
    .oERR_STICKY   (err),
    .iCLR_ERR      (clr)
`ifdef TX_ARB_STATS_EN
    ,
    .oTLP_CNT      (tlp_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, a one-cycle cool-down after each burst,
  // and the last owner for round-robin ordering.
  int               m_owner;
  bit               m_dead;
  int               m_last;
  logic [0:0]       m_idx;
  tx_st_avalon_type m_tx;
  logic [255:0]     m_data;
  logic [1:0]       m_err;

  function automatic void model_reset();
    m_owner = -1;
    m_dead  = 1'b0;
    m_last  = REQS - 1;
    m_idx   = '0;
    m_tx    = '0;
    m_tx.empty = AVALON_255_0_VALID;
    m_data  = '0;
    m_err   = '0;
  endfunction

  function automatic logic [1:0] model_gnt();
    return (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
  endfunction

  function automatic void model_edge();
    logic [1:0] set;
    logic [1:0] gv;
    int j;
    gv     = model_gnt();
    set[0] = !rdy && m_tx.valid;
    set[1] = |({in_st[1].valid, in_st[0].valid} & ~gv);
    if (m_owner >= 0) begin
      m_tx   = in_st[m_owner];
      m_data = in_data[m_owner];
    end else begin
      m_tx.sop    = 1'b0;
      m_tx.eop    = 1'b0;
      m_tx.valid  = 1'b0;
      m_tx.empty  = AVALON_255_0_VALID;
      m_tx.err    = in_st[m_idx].err;
      m_tx.parity = in_st[m_idx].parity;
      m_data      = '0;
    end
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_dead  = 1'b1;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (rdy && req != 2'b00) begin
      for (int k = 1; k <= REQS; k++) begin
        j = (m_last + k) % REQS;
        if (m_owner < 0 && req[j]) m_owner = j;
      end
      m_idx = 1'(m_owner);
    end
    m_err = (clr ? 2'b00 : m_err) | set;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check(name, {gnt, out_st, out_data, gnt_idx, err},
          {model_gnt(), m_tx, m_data, m_idx, m_err});
  endtask

  // Requester behaviour: hold iREQ from request through the last EOP, stream beats
  // only while owning the port.
  bit en[2], want[2], oneshot;
  int beat[2], tot[2], tlp[2], gap[2];
  int tlp_fix, tlps_fix, gap_max, stray_pct;

  task automatic eng_init(input bit e0, input bit e1, input int tf, input int nt,
                          input int gm, input bit os, input int sp);
    en[0] = e0; en[1] = e1;
    tlp_fix = tf; tlps_fix = nt; gap_max = gm; oneshot = os; stray_pct = sp;
    for (int i = 0; i < 2; i++) begin
      want[i] = 1'b0; beat[i] = 0; tot[i] = 0; tlp[i] = 1; gap[i] = 0;
    end
  endtask

  task automatic drive_engine();
    for (int i = 0; i < 2; i++) begin
      in_st[i]        = '0;
      in_st[i].err    = 1'($urandom);
      in_st[i].parity = $urandom;
      for (int w = 0; w < 8; w++) in_data[i][w*32 +: 32] = $urandom;
      if (want[i] && m_owner == i) begin
        if (beat[i] < tot[i]) begin
          in_st[i].valid = 1'b1;
          in_st[i].sop   = (beat[i] % tlp[i] == 0);
          in_st[i].eop   = (beat[i] % tlp[i] == tlp[i] - 1);
          in_st[i].empty = in_st[i].eop ? AVALON_127_0_VALID : AVALON_255_0_VALID;
          beat[i]++;
        end else begin
          want[i] = 1'b0;
          gap[i]  = $urandom_range(0, gap_max);
          if (oneshot) en[i] = 1'b0;
        end
      end else begin
        if ($urandom_range(0, 99) < stray_pct) in_st[i].valid = 1'b1;
        if (!want[i] && en[i]) begin
          if (gap[i] == 0) begin
            want[i] = 1'b1;
            beat[i] = 0;
            tlp[i]  = (tlp_fix > 0) ? tlp_fix : $urandom_range(1, 4);
            tot[i]  = tlp[i] * ((tlps_fix > 0) ? tlps_fix : $urandom_range(1, 2));
          end else begin
            gap[i]--;
          end
        end
      end
      req[i] = want[i];
    end
  endtask

  task automatic quiet_inputs();
    req = '0; clr = 1'b0; rdy = 1'b1;
    in_st = '0; in_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet_inputs();
    eng_init(0, 0, 0, 0, 0, 0, 0);
    step("reset_a");
    step("reset_b");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic       rdy, clr, v0, v1;
    logic [1:0] gnt;
    logic       v;
    logic [1:0] err;
  } vec_t;

  vec_t tbl[16];
  int   grants[$];
  logic [1:0] prev_gnt;
  int   idle_run, min_idle;
  logic [255:0] marker;
  tx_st_avalon_type rst_tx;

  initial begin
    model_reset();
    rst_n = 1'b0;
    quiet_inputs();

    // ---- scripted table: ready-low arbitration, ready drop, clears, stray valid
    tbl[0]  = '{2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00};
    tbl[1]  = '{2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00};
    tbl[2]  = '{2'b01, 1, 0, 0, 0, 2'b01, 0, 2'b00};
    tbl[3]  = '{2'b01, 1, 0, 1, 0, 2'b01, 1, 2'b00};
    tbl[4]  = '{2'b01, 0, 0, 1, 0, 2'b01, 1, 2'b01};
    tbl[5]  = '{2'b01, 1, 0, 1, 0, 2'b01, 1, 2'b01};
    tbl[6]  = '{2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b01};
    tbl[7]  = '{2'b00, 1, 1, 0, 0, 2'b00, 0, 2'b00};
    tbl[8]  = '{2'b11, 1, 0, 0, 0, 2'b10, 0, 2'b00};
    tbl[9]  = '{2'b11, 1, 0, 1, 0, 2'b10, 0, 2'b10};
    tbl[10] = '{2'b01, 1, 1, 0, 0, 2'b00, 0, 2'b00};
    tbl[11] = '{2'b01, 1, 0, 0, 0, 2'b00, 0, 2'b00};
    tbl[12] = '{2'b01, 1, 0, 0, 0, 2'b01, 0, 2'b00};
    tbl[13] = '{2'b01, 1, 1, 0, 1, 2'b01, 0, 2'b10};
    tbl[14] = '{2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b10};
    tbl[15] = '{2'b00, 1, 1, 0, 0, 2'b00, 0, 2'b00};

    do_reset();
    for (int r = 0; r < 16; r++) begin
      req = tbl[r].req; rdy = tbl[r].rdy; clr = tbl[r].clr;
      in_st = '0;
      in_st[0].valid = tbl[r].v0;
      in_st[1].valid = tbl[r].v1;
      for (int i = 0; i < 2; i++)
        for (int w = 0; w < 8; w++) in_data[i][w*32 +: 32] = $urandom;
      step($sformatf("tbl%0d_model", r));
      check($sformatf("tbl%0d", r), {gnt, out_st.valid, err},
            {tbl[r].gnt, tbl[r].v, tbl[r].err});
    end

    // ---- single requester, two 9-beat TLPs
    do_reset();
    eng_init(1, 0, 9, 2, 0, 1, 0);
    drive_engine();
    step("single_c0");
    check("single_gnt", gnt, 2'b01);
    for (int c = 1; c < 26; c++) begin
      drive_engine();
      step($sformatf("single_c%0d", c));
    end
    check("single_err", err, 2'b00);

    // ---- round-robin with both requesters always re-requesting
    do_reset();
    eng_init(1, 1, 3, 1, 0, 0, 0);
    grants.delete();
    prev_gnt = 2'b00; idle_run = 0; min_idle = 99;
    for (int c = 0; c < 40; c++) begin
      drive_engine();
      step($sformatf("rr_c%0d", c));
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        grants.push_back(gnt == 2'b10 ? 1 : 0);
        if (grants.size() > 1 && idle_run < min_idle) min_idle = idle_run;
        idle_run = 0;
      end else if (gnt == 2'b00) begin
        idle_run++;
      end
      prev_gnt = gnt;
    end
    check("rr_count", (grants.size() >= 4), 1'b1);
    if (grants.size() >= 4)
      check("rr_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]},
            {2'd0, 2'd1, 2'd0, 2'd1});
    check("rr_min_idle", (min_idle >= 1), 1'b1);

    // ---- ungranted valid, then reset during the 5th beat of a burst
    do_reset();
    eng_init(1, 0, 9, 1, 0, 1, 0);
    marker = {8{32'hDEADBEEF}};
    for (int c = 0; c < 5; c++) begin
      drive_engine();
      in_data[1] = marker;
      if (c == 2) in_st[1].valid = 1'b1;
      step($sformatf("rst_pre_c%0d", c));
      check($sformatf("ungnt_data_c%0d", c), (out_data == marker), 1'b0);
    end
    check("ungnt_err", err, 2'b10);
    drive_engine();
    step("rst_beat5");
    check("rst_beat5_valid", out_st.valid, 1'b1);
    rst_n = 1'b0;
    #1;
    rst_tx = '0;
    rst_tx.empty = AVALON_255_0_VALID;
    check("rst_async", {gnt, out_st, out_data, gnt_idx, err},
          {2'b00, rst_tx, 256'd0, 1'b0, 2'b00});
    model_reset();
    quiet_inputs();
    eng_init(0, 0, 0, 0, 0, 0, 0);
    step("rst_hold");
    rst_n = 1'b1;
    eng_init(0, 1, 2, 1, 0, 1, 0);
    drive_engine();
    step("rst_after_c0");
    check("rst_first_gnt", gnt, 2'b10);
    for (int c = 1; c < 10; c++) begin
      drive_engine();
      step($sformatf("rst_after_c%0d", c));
    end

    // ---- randomized traffic with ready drops, clears and stray valids
    do_reset();
    eng_init(1, 1, 0, 0, 3, 0, 2);
    for (int c = 0; c < 800; c++) begin
      drive_engine();
      rdy = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) < 8);
      step($sformatf("rand_c%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
